vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised VGA/SVGA timing generator. It is the next generation of the project's fixed 640x480 driver.
- Adds runtime-independent resolution parameters, selectable sync polarity, an internal pixel-clock-enable divider, a pause enable, and frame/line start strobes.
- Sits between the system clock domain and the pixel renderer (snake board/sprite logic) and the VGA connector pins.
- All outputs are registered and mutually aligned.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, 1 = hsync active-high, 0 = active-low
- VSYNC_POL, 0, 1 = vsync active-high, 0 = active-low
- CLK_DIV, 1, VGA_clk cycles per pixel (1..16); 4 gives 25 MHz pixels from 100 MHz
- CNT_W, 10, counter/coordinate width

Ports:
- VGA_clk, input, 1, system clock; single clock domain
- reset, input, 1, asynchronous active-high reset
- enable, input, 1, 1 = timing runs; 0 = freeze all state
- pixel_tick, output, 1, one-VGA_clk strobe on each pixel advance
- xCount, output, CNT_W, horizontal coordinate of the currently presented pixel
- yCount, output, CNT_W, vertical coordinate of the currently presented pixel
- video_on, output, 1, presented pixel is inside the visible area
- VGA_hSync, output, 1, horizontal sync at HSYNC_POL polarity
- VGA_vSync, output, 1, vertical sync at VSYNC_POL polarity
- line_start, output, 1, strobe when presented pixel has xCount==0
- frame_start, output, 1, strobe when presented pixel has xCount==0 and yCount==0

Behaviour:
- Clock and reset: one clock VGA_clk; reset is asynchronous and active-high.
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800)
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525)
  - Elaboration fails if H_TOTAL or V_TOTAL exceeds 2^CNT_W, or if CLK_DIV is 0.
- Reset state (asynchronous, immediate):
  - divider = 0, h_cnt = 0, v_cnt = 0
  - xCount = 0, yCount = 0, video_on = 0
  - VGA_hSync = ~HSYNC_POL, VGA_vSync = ~VSYNC_POL (inactive levels)
  - pixel_tick = 0, line_start = 0, frame_start = 0
- Divider:
  - Counts 0..CLK_DIV-1 while enable=1 and wraps to 0.
  - Internal tick is asserted when divider==CLK_DIV-1 and enable=1.
  - With CLK_DIV=1, tick = enable.
- Counters, advancing only on tick:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - v_cnt increments only when h_cnt wraps; at V_TOTAL-1 it wraps to 0.
  - Both wrap on the same tick at (H_TOTAL-1, V_TOTAL-1).
- Output stage, loaded on tick from the pre-increment h_cnt/v_cnt:
  - xCount <= h_cnt, yCount <= v_cnt
  - video_on <= (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY)
  - hsync active when H_DISPLAY+H_FRONT <= h_cnt <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751 by default)
  - vsync active when V_DISPLAY+V_FRONT <= v_cnt <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491 by default)
  - Sync pins are driven at the parameter polarity, inactive level otherwise.
  - line_start <= (h_cnt==0)
  - frame_start <= (h_cnt==0 && v_cnt==0)
- Timing and latency:
  - Outputs change only in the cycle after a tick and hold between ticks.
  - All outputs describe the same pixel; there is no cross-signal skew.
- Strobes:
  - pixel_tick, line_start and frame_start are high for exactly one VGA_clk cycle: the cycle in which the output stage has just loaded.
  - They are 0 in every other cycle, including when CLK_DIV=1 and enable stays high.
  - Exception: with CLK_DIV=1, pixel_tick is continuously 1 while enable=1.
- enable=0:
  - Divider, counters and output registers hold their values.
  - Strobes drop to 0 the next cycle.
  - On re-enable, counting resumes from the held divider value; there is no skipped or duplicated pixel.
- Reset mid-frame: all state returns to the reset values immediately. After release, the first tick presents (0,0) with frame_start=1.
- Arithmetic: unsigned, CNT_W bits, no saturation. Comparisons use the full CNT_W width.

Test Plan:
- Default params, CLK_DIV=1, enable=1, release reset → first output cycle xCount=0, yCount=0, video_on=1, frame_start=1, line_start=1; hsync=1 and vsync=1 (inactive-low).
- Run one line → VGA_hSync=0 exactly for xCount 656..751 (96 pixels); video_on falls when xCount=640; line_start period is 800 clocks.
- Run a full frame → VGA_vSync=0 exactly for yCount 490..491; frame_start period is 800*525=420000 clocks; yCount wraps 524→0 at the same time xCount wraps 799→0.
- CLK_DIV=4 → pixel_tick every 4th VGA_clk; xCount is stable for 4 cycles; line period is 3200 clocks; strobes are one cycle wide.
- HSYNC_POL=1, VSYNC_POL=1, small params (H 8/2/2/2, V 4/1/1/1, CNT_W=4) → hsync high for x=10..11; vsync high for y=5; H_TOTAL=14, V_TOTAL=7.
- Drop enable for 5 cycles at xCount=300, then pulse reset at xCount=400 → outputs frozen at 300 during the pause, then continue to 301; after reset, all outputs are at their reset values asynchronously and the sequence restarts at (0,0).

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA timing generator: pixel-clock-enable divider, h/v counters
// and a registered output stage in which every output describes the same pixel.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV   = 1,
    parameter int CNT_W     = 10
) (
    input  logic             VGA_clk,
    input  logic             reset,
    input  logic             enable,
    output logic             pixel_tick,
    output logic [CNT_W-1:0] xCount,
    output logic [CNT_W-1:0] yCount,
    output logic             video_on,
    output logic             VGA_hSync,
    output logic             VGA_vSync,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    if (H_TOTAL > (1 << CNT_W)) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (V_TOTAL > (1 << CNT_W)) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] divider;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             tick;

    assign tick = enable && (divider == DIV_LAST);

    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            divider     <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            xCount      <= '0;
            yCount      <= '0;
            video_on    <= 1'b0;
            VGA_hSync   <= ~HSYNC_POL;
            VGA_vSync   <= ~VSYNC_POL;
            pixel_tick  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // Strobes mark the single cycle right after the output stage loads.
            pixel_tick  <= tick;
            line_start  <= tick && (h_cnt == '0);
            frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);

            if (enable) begin
                divider <= (divider == DIV_LAST) ? '0 : divider + DIV_W'(1);
            end

            if (tick) begin
                // Output stage presents the pre-increment position.
                xCount    <= h_cnt;
                yCount    <= v_cnt;
                video_on  <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
                VGA_hSync <= (h_cnt >= HS_FIRST && h_cnt <= HS_LAST) ? HSYNC_POL : ~HSYNC_POL;
                VGA_vSync <= (v_cnt >= VS_FIRST && v_cnt <= VS_LAST) ? VSYNC_POL : ~VSYNC_POL;

                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
                end else begin
                    h_cnt <= h_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
